// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART serialiser/deserialiser.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2,
    PAR_RSVD = 2'd3   // behaves like PAR_NONE
  } parity_t;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  // 0..3 -> 5..8 data bits
  function automatic logic [3:0] data_bits_to_count(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction

  function automatic logic parity_enabled(input parity_t par);
    return (par == PAR_EVEN) || (par == PAR_ODD);
  endfunction

  // XOR over the configured data bits only, inverted for odd parity
  function automatic logic parity_calc(input logic [7:0] data, input logic [1:0] code,
                                       input parity_t par);
    logic [7:0] mask;
    mask = 8'hFF >> (3'd3 - {1'b0, code});
    return (^(data & mask)) ^ (par == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: os_tick pulses once every divisor+1 clocks.
module uart_baud_gen #(
  parameter int CLK_DIV_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CLK_DIV_WIDTH-1:0] divisor,
  output logic                     os_tick
);

  logic [CLK_DIV_WIDTH-1:0] cnt_q, cnt_d;

  assign os_tick = (cnt_q == divisor);

  // free-running counter that wraps on the tick
  always_comb begin
    cnt_d = cnt_q + {{(CLK_DIV_WIDTH-1){1'b0}}, 1'b1};
    if (os_tick) cnt_d = '0;
  end

  // counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_serdes.sv
// Full-duplex UART engine: TX serialiser, RX deserialiser, shared baud generator.
// Handshakes: a byte moves when valid && ready are both high on a rising clk edge;
// valid holds its data until then and never depends combinationally on ready.
module uart_serdes #(
  parameter int CLK_DIV_WIDTH = 16,
  parameter int OVERSAMPLE    = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CLK_DIV_WIDTH-1:0] cfg_divisor,
  input  logic [1:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic                     cfg_two_stop,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     tx,
  output logic                     tx_busy,
  input  logic                     rx,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err,
  output logic                     rx_overrun,
  output logic                     rx_busy
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);

  logic os_tick;

  uart_baud_gen #(.CLK_DIV_WIDTH(CLK_DIV_WIDTH)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .divisor (cfg_divisor),
    .os_tick (os_tick)
  );

  // ---------------- TX ----------------
  tx_state_t  tx_state_q, tx_state_d;
  logic [TW-1:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_idx_q, tx_idx_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [1:0] tx_bits_q, tx_bits_d;
  parity_t    tx_par_q, tx_par_d;
  logic       tx_two_q, tx_two_d;
  logic       tx_q, tx_d;
  logic       tx_end;

  assign tx_end   = os_tick && (tx_tick_q == TICK_LAST);
  assign tx_ready = (tx_state_q == TX_IDLE);
  assign tx_busy  = !tx_ready;
  assign tx       = tx_q;

  // TX next state; the line level is registered from the next state to stay glitch-free
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_idx_d   = tx_idx_q;
    tx_byte_d  = tx_byte_q;
    tx_bits_d  = tx_bits_q;
    tx_par_d   = tx_par_q;
    tx_two_d   = tx_two_q;
    if (os_tick && tx_state_q != TX_IDLE) tx_tick_d = tx_tick_q + TW'(1);
    case (tx_state_q)
      TX_IDLE: if (tx_valid) begin
        tx_byte_d  = tx_data;
        tx_bits_d  = cfg_data_bits;
        tx_par_d   = parity_t'(cfg_parity);
        tx_two_d   = cfg_two_stop;
        tx_tick_d  = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_end) begin
        tx_idx_d   = 3'd0;
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_end) begin
        if ({1'b0, tx_idx_q} == data_bits_to_count(tx_bits_q) - 4'd1)
          tx_state_d = parity_enabled(tx_par_q) ? TX_PARITY : TX_STOP1;
        else
          tx_idx_d = tx_idx_q + 3'd1;
      end
      TX_PARITY: if (tx_end) tx_state_d = TX_STOP1;
      TX_STOP1:  if (tx_end) tx_state_d = tx_two_q ? TX_STOP2 : TX_IDLE;
      TX_STOP2:  if (tx_end) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_byte_d[tx_idx_d];
      TX_PARITY: tx_d = parity_calc(tx_byte_d, tx_bits_d, tx_par_d);
      default:   tx_d = 1'b1;
    endcase
  end

  // TX registers; reset drives the line high at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_idx_q   <= '0;
      tx_byte_q  <= '0;
      tx_bits_q  <= '0;
      tx_par_q   <= PAR_NONE;
      tx_two_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_idx_q   <= tx_idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_bits_q  <= tx_bits_d;
      tx_par_q   <= tx_par_d;
      tx_two_q   <= tx_two_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------- RX ----------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // input synchroniser, preset to the idle level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

  rx_state_t  rx_state_q, rx_state_d;
  logic [TW-1:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_idx_q, rx_idx_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [1:0] rx_bits_q, rx_bits_d;
  parity_t    rx_par_q, rx_par_d;
  logic       rx_pbit_q, rx_pbit_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_perr_q, rx_perr_d;
  logic       rx_ferr_q, rx_ferr_d;
  logic       rx_ovr_q, rx_ovr_d;
  logic       rx_half, rx_full, stop_sample;

  assign rx_half       = os_tick && (rx_tick_q == TICK_HALF);
  assign rx_full       = os_tick && (rx_tick_q == TICK_LAST);
  assign rx_busy       = (rx_state_q != RX_IDLE);
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

  // RX next state, byte assembly and output slot management
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tick_d   = rx_tick_q;
    rx_idx_d    = rx_idx_q;
    rx_shift_d  = rx_shift_q;
    rx_bits_d   = rx_bits_q;
    rx_par_d    = rx_par_q;
    rx_pbit_d   = rx_pbit_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    rx_perr_d   = rx_perr_q;
    rx_ferr_d   = rx_ferr_q;
    rx_ovr_d    = rx_ovr_q;
    stop_sample = 1'b0;
    if (os_tick) rx_tick_d = rx_tick_q + TW'(1);
    case (rx_state_q)
      RX_IDLE: if (!rx_s) begin
        rx_tick_d  = '0;
        rx_shift_d = '0;
        rx_bits_d  = cfg_data_bits;
        rx_par_d   = parity_t'(cfg_parity);
        rx_state_d = RX_START;
      end
      RX_START: if (rx_half) begin
        // re-phase the counter so later samples land on bit centres
        rx_tick_d  = '0;
        rx_idx_d   = 3'd0;
        rx_state_d = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_full) begin
        rx_shift_d[rx_idx_q] = rx_s;
        if ({1'b0, rx_idx_q} == data_bits_to_count(rx_bits_q) - 4'd1)
          rx_state_d = parity_enabled(rx_par_q) ? RX_PARITY : RX_STOP;
        else
          rx_idx_d = rx_idx_q + 3'd1;
      end
      RX_PARITY: if (rx_full) begin
        rx_pbit_d  = rx_s;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_full) begin
        stop_sample = 1'b1;
        // a low stop bit means a break may be in progress: wait for the line to recover
        rx_state_d  = rx_s ? RX_IDLE : RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: if (rx_s) rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      rx_perr_d  = 1'b0;
      rx_ferr_d  = 1'b0;
      rx_ovr_d   = 1'b0;
    end
    if (stop_sample) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_perr_d  = parity_enabled(rx_par_q) &&
                     (parity_calc(rx_shift_q, rx_bits_q, rx_par_q) != rx_pbit_q);
        rx_ferr_d  = !rx_s;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  // RX registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_bits_q  <= '0;
      rx_par_q   <= PAR_NONE;
      rx_pbit_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_bits_q  <= rx_bits_d;
      rx_par_q   <= rx_par_d;
      rx_pbit_q  <= rx_pbit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_serdes.sv
// Directed bench for uart_serdes: TX timing, loopback with parity, false start,
// break, overrun and mid-frame reset.
module tb_uart_serdes;

  localparam int CDW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [CDW-1:0] cfg_divisor;
  logic [1:0]     cfg_data_bits, cfg_parity;
  logic           cfg_two_stop;
  logic [7:0]     tx_data;
  logic           tx_valid, tx_ready, tx, tx_busy;
  logic           rx_pin, rx_drv, loopback;
  logic [7:0]     rx_data;
  logic           rx_valid, rx_ready, rx_parity_err, rx_frame_err, rx_overrun, rx_busy;

  assign rx_pin = loopback ? tx : rx_drv;

  uart_serdes #(.CLK_DIV_WIDTH(CDW), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_divisor   (cfg_divisor),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_two_stop  (cfg_two_stop),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .rx            (rx_pin),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rx_overrun    (rx_overrun),
    .rx_busy       (rx_busy)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int   pulses = 0;
  logic valid_prev = 1'b0;

  // count rising edges of rx_valid
  always @(posedge clk) begin
    valid_prev <= rx_valid;
    if (rx_valid && !valid_prev) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rx(input string tag, input logic perr, input logic ferr);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, {24'd0, rx_data}, {24'd0, e});
    end
    check({tag, "_perr"}, {31'd0, rx_parity_err}, {31'd0, perr});
    check({tag, "_ferr"}, {31'd0, rx_frame_err}, {31'd0, ferr});
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("send_tx_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input string tag, input int max_clk);
    int n;
    n = 0;
    while (!rx_valid && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, rx_valid}, 32'd1);
  endtask

  task automatic consume();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((tx_busy || rx_busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'd0, tx_busy, rx_busy}, 32'd0);
  endtask

  // drive one frame on the rx line; leaves the line at the stop-bit level
  task automatic drive_rx_frame(input logic [7:0] d, input int nbits, input logic par_en,
                                input logic par_odd, input logic stop_val, input int bit_clks);
    logic p;
    p = par_odd;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = d[i];
      p      = p ^ d[i];
      repeat (bit_clks) @(negedge clk);
    end
    if (par_en) begin
      rx_drv = p;
      repeat (bit_clks) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (bit_clks) @(negedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] frame;
    int p0;
    reset         = 1'b0;
    cfg_divisor   = '0;
    cfg_data_bits = 2'd3;
    cfg_parity    = 2'd0;
    cfg_two_stop  = 1'b0;
    tx_data       = '0;
    tx_valid      = 1'b0;
    rx_ready      = 1'b0;
    rx_drv        = 1'b1;
    loopback      = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_tx",       {31'd0, tx},            32'd1);
    check("rst_tx_ready", {31'd0, tx_ready},      32'd1);
    check("rst_tx_busy",  {31'd0, tx_busy},       32'd0);
    check("rst_rx_valid", {31'd0, rx_valid},      32'd0);
    check("rst_rx_data",  {24'd0, rx_data},       32'd0);
    check("rst_errs",     {29'd0, rx_parity_err, rx_frame_err, rx_overrun}, 32'd0);
    check("rst_rx_busy",  {31'd0, rx_busy},       32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: div=0, 8N1, 0x55 -- exact bit timing
    frame = {1'b1, 8'h55, 1'b0};
    send_byte(8'h55);
    for (int c = 0; c <= 160; c++) begin
      @(negedge clk);
      if (c < 160 && (c % 16) == 8) check($sformatf("t1_bit%0d", c / 16), {31'd0, tx}, {31'd0, frame[c / 16]});
      if (c == 15)  check("t1_start_end",   {31'd0, tx}, 32'd0);
      if (c == 16)  check("t1_d0_begin",    {31'd0, tx}, 32'd1);
      if (c == 80)  check("t1_busy",        {31'd0, tx_busy}, 32'd1);
      if (c == 159) check("t1_ready_early", {31'd0, tx_ready}, 32'd0);
      if (c == 160) check("t1_ready_160",   {31'd0, tx_ready}, 32'd1);
    end

    // 2: loopback, div=3, 7E2 then 7O1 (upper bit of 0xBA must be ignored)
    wait_idle("t2_idle_a");
    cfg_divisor   = 16'd3;
    cfg_data_bits = 2'd2;
    cfg_parity    = 2'd1;
    cfg_two_stop  = 1'b1;
    loopback      = 1'b1;
    exp_q.push_back(8'h3A);
    send_byte(8'h3A);
    repeat (544) @(negedge clk);
    check("t2_even_pbit", {31'd0, tx}, 32'd0);
    wait_rx("t2_even_valid", 1500);
    check_rx("t2_even", 1'b0, 1'b0);
    consume();
    check("t2_even_consumed", {31'd0, rx_valid}, 32'd0);

    wait_idle("t2_idle_b");
    cfg_parity   = 2'd2;
    cfg_two_stop = 1'b0;
    exp_q.push_back(8'h3A);
    send_byte(8'hBA);
    repeat (544) @(negedge clk);
    check("t2_odd_pbit", {31'd0, tx}, 32'd1);
    wait_rx("t2_odd_valid", 1500);
    check_rx("t2_odd", 1'b0, 1'b0);
    consume();

    // 3: false start, 5 os_ticks low (20 clk at div=3)
    wait_idle("t3_idle");
    loopback      = 1'b0;
    cfg_data_bits = 2'd3;
    cfg_parity    = 2'd0;
    p0            = pulses;
    rx_drv        = 1'b0;
    repeat (20) @(negedge clk);
    check("t3_busy_start", {31'd0, rx_busy}, 32'd1);
    rx_drv = 1'b1;
    repeat (44) @(negedge clk);
    check("t3_busy_clear", {31'd0, rx_busy}, 32'd0);
    repeat (700) @(negedge clk);
    check("t3_no_valid", pulses - p0, 32'd0);

    // 4: break frame 0x00 with low stop, line low 40 bit times, then a clean 0xA5
    p0 = pulses;
    exp_q.push_back(8'h00);
    drive_rx_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 64);
    repeat (30 * 64) @(negedge clk);
    check("t4_wait_high", {31'd0, rx_busy}, 32'd1);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    check("t4_one_valid", pulses - p0, 32'd1);
    check("t4_valid", {31'd0, rx_valid}, 32'd1);
    check_rx("t4_break", 1'b0, 1'b1);
    consume();
    check("t4_rearmed", {31'd0, rx_busy}, 32'd0);
    exp_q.push_back(8'hA5);
    drive_rx_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 64);
    wait_rx("t4_a5_valid", 200);
    check_rx("t4_a5", 1'b0, 1'b0);
    consume();

    // 5: overrun -- two frames without consuming
    exp_q.push_back(8'h11);
    drive_rx_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 64);
    drive_rx_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 64);
    repeat (10) @(negedge clk);
    check("t5_valid", {31'd0, rx_valid}, 32'd1);
    check_rx("t5_held", 1'b0, 1'b0);
    check("t5_overrun", {31'd0, rx_overrun}, 32'd1);
    consume();
    check("t5_valid_clr", {31'd0, rx_valid}, 32'd0);
    check("t5_overrun_clr", {31'd0, rx_overrun}, 32'd0);

    // 6: reset during TX data bit 3 and RX data bit 2
    send_byte(8'hF0);
    repeat (63) @(negedge clk);
    rx_drv = 1'b0;
    repeat (64) @(negedge clk);
    rx_drv = 1'b1;
    repeat (128 + 14) @(negedge clk);
    check("t6_tx_bit3", {31'd0, tx}, 32'd0);
    check("t6_busy_pre", {30'd0, tx_busy, rx_busy}, 32'd3);
    reset = 1'b0;
    #1;
    check("t6_tx_async", {31'd0, tx}, 32'd1);
    check("t6_busy_rst", {30'd0, tx_busy, rx_busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("t6_rx_valid", {31'd0, rx_valid}, 32'd0);
    loopback = 1'b1;
    exp_q.push_back(8'hC3);
    send_byte(8'hC3);
    wait_rx("t6_c3_valid", 1500);
    check_rx("t6_c3", 1'b0, 1'b0);
    consume();
    check("t6_sb_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
